// File: rtl/synth_pkg.sv
// Shared definitions for the voice synthesis slice: sine unit geometry,
// scheduler FSM encoding and index-width helper.
package synth_pkg;

  localparam int unsigned PHASE_W  = 16;
  localparam int unsigned SINE_W   = 16;
  localparam int unsigned SINE_LAT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Width of a voice index; never narrower than one bit.
  function automatic int unsigned vidx_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/delay_pipe.sv
// Parameterised shift register used to align side-band flags with a
// fixed-latency datapath.
module delay_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/voice_sine_scheduler.sv
// Time-multiplexes one shared sine pipeline over NUM_VOICES phase
// accumulators and mixes the enabled voices into one sample per tick.
module voice_sine_scheduler
  import synth_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned PHASE_W    = synth_pkg::PHASE_W,
  parameter int unsigned SINE_LAT   = synth_pkg::SINE_LAT,
  parameter int unsigned MIX_W      = 19,
  localparam int unsigned VW        = vidx_w(NUM_VOICES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  freq_we,
  input  logic [VW-1:0]         freq_addr,
  input  logic [PHASE_W-1:0]    freq_data,
  input  logic [NUM_VOICES-1:0] voice_en,
  output logic [PHASE_W-1:0]    phase_out,
  input  logic [SINE_W-1:0]     sine_in,
  output logic [MIX_W-1:0]      sample_out,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);

  logic [PHASE_W-1:0] acc [NUM_VOICES];
  logic [PHASE_W-1:0] inc [NUM_VOICES];

  state_t        state, state_nx;
  logic [VW-1:0] v;
  logic [VW-1:0] v_nx;
  logic          start;
  logic          issue;

  logic [2:0]    pipe_in;
  logic [2:0]    pipe_out;
  logic          d_valid, d_en, d_last;

  logic [MIX_W-1:0] mix;
  logic [MIX_W-1:0] sine_ext;
  logic [MIX_W-1:0] mix_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          start    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (v == LAST_V) state_nx = DRAIN;
      end
      DRAIN: begin
        if (d_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign v_nx = v + 1'b1;

  // Flags ride alongside the sine latency: {valid, enable-at-issue, last voice}.
  assign pipe_in = {issue, issue & voice_en[v], issue & (v == LAST_V)};

  delay_pipe #(
    .WIDTH (3),
    .DEPTH (SINE_LAT)
  ) u_align (
    .clk  (clk),
    .rst  (rst),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  assign d_valid  = pipe_out[2];
  assign d_en     = pipe_out[1];
  assign d_last   = pipe_out[0];
  assign sine_ext = {{(MIX_W - SINE_W){sine_in[SINE_W-1]}}, sine_in};
  assign mix_sum  = d_en ? (mix + sine_ext) : mix;

  // phase_out is loaded one edge ahead of the issue cycle so voice v is
  // visible during cycle v; acc[v] advances at the edge ending cycle v.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        acc[i] <= '0;
        inc[i] <= '0;
      end
      v            <= '0;
      phase_out    <= '0;
      mix          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;

      if (freq_we) inc[freq_addr] <= freq_data;

      if (sample_tick && (state != IDLE)) overrun <= 1'b1;

      if (start) begin
        v         <= '0;
        phase_out <= acc[0];
        mix       <= '0;
      end

      if (issue) begin
        v <= v_nx;
        if (voice_en[v]) acc[v] <= acc[v] + inc[v];
        if (v != LAST_V) phase_out <= acc[v_nx];
      end

      if (d_valid) begin
        mix <= mix_sum;
        if (d_last) begin
          sample_out   <= mix_sum;
          sample_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_sine_scheduler.sv
// Directed bench for voice_sine_scheduler with a 3-cycle sine stub.
`timescale 1ns/1ps
module tb_voice_sine_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_tick = 1'b0;
  logic        freq_we = 1'b0;
  logic [2:0]  freq_addr = '0;
  logic [15:0] freq_data = '0;
  logic [7:0]  voice_en = '0;
  logic [15:0] phase_out;
  logic [15:0] sine_in;
  logic [18:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  // sine stub: 0 = echo phase as signed, 1 = +full scale, 2 = -full scale
  int          mode = 0;
  logic [15:0] p1 = '0, p2 = '0, p3 = '0;

  logic [15:0] ph [8];
  logic [18:0] samp;
  int          vcyc;
  bit          busy_ok;

  voice_sine_scheduler #(
    .NUM_VOICES (8),
    .PHASE_W    (16),
    .SINE_LAT   (3),
    .MIX_W      (19)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .freq_we      (freq_we),
    .freq_addr    (freq_addr),
    .freq_data    (freq_data),
    .voice_en     (voice_en),
    .phase_out    (phase_out),
    .sine_in      (sine_in),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1 <= phase_out;
    p2 <= p1;
    p3 <= p2;
  end

  always_comb begin
    sine_in = p3;
    if (mode == 1) sine_in = 16'h7FFF;
    else if (mode == 2) sine_in = 16'h8000;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    freq_we = 1'b1; freq_addr = a; freq_data = d;
    step();
    freq_we = 1'b0;
  endtask

  // Starts in cycle 0 of a frame; optional injection: 1 = tick, 2 = freq write.
  task automatic collect(input int inj_cyc, input int inj_kind,
                         input logic [15:0] inj_data, input logic [2:0] inj_addr,
                         input bit stop);
    bit done;
    done = 1'b0; vcyc = -1; busy_ok = 1'b1; samp = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c < 8) ph[c] = phase_out;
      if (sample_valid) begin
        done = 1'b1; vcyc = c; samp = sample_out;
        if (busy) busy_ok = 1'b0;
      end else if (!busy) busy_ok = 1'b0;
      if (c == inj_cyc && inj_kind == 1) sample_tick = 1'b1;
      if (c == inj_cyc && inj_kind == 2) begin
        freq_we = 1'b1; freq_addr = inj_addr; freq_data = inj_data;
      end
      if (!(done && stop)) begin
        step();
        sample_tick = 1'b0;
        freq_we = 1'b0;
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL frame_timeout: got no sample_valid expected one within 40 cycles");
    end
  endtask

  task automatic frame(input logic [7:0] en, input int inj_cyc, input int inj_kind,
                       input logic [15:0] inj_data, input logic [2:0] inj_addr,
                       input bit stop);
    voice_en = en;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    collect(inj_cyc, inj_kind, inj_data, inj_addr, stop);
  endtask

  typedef struct {
    logic [7:0]  en;
    int          md;
    logic [15:0] ph0;
    logic [18:0] smp;
  } vec_t;

  vec_t tbl [11];

  initial begin
    // inc[0]=0x1000, all others 0; acc[0] advances only on enabled frames
    tbl[0]  = '{8'h01, 0, 16'h0000, 19'h00000};
    tbl[1]  = '{8'h01, 0, 16'h1000, 19'h01000};
    tbl[2]  = '{8'h01, 0, 16'h2000, 19'h02000};
    tbl[3]  = '{8'h00, 0, 16'h3000, 19'h00000};
    tbl[4]  = '{8'h01, 0, 16'h3000, 19'h03000};
    tbl[5]  = '{8'hFF, 1, 16'h4000, 19'h3FFF8};
    tbl[6]  = '{8'hFF, 2, 16'h5000, 19'h40000};
    tbl[7]  = '{8'h0F, 1, 16'h6000, 19'h1FFFC};
    tbl[8]  = '{8'h80, 2, 16'h7000, 19'h78000};
    tbl[9]  = '{8'h01, 0, 16'h7000, 19'h07000};
    tbl[10] = '{8'h01, 0, 16'h8000, 19'h78000};

    do_reset();
    check("rst_phase_out", 32'(phase_out), 32'h0);
    check("rst_sample_out", 32'(sample_out), 32'h0);
    check("rst_sample_valid", 32'(sample_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);

    wr(3'd0, 16'h1000);
    for (int i = 0; i < 11; i++) begin
      mode = tbl[i].md;
      frame(tbl[i].en, -1, 0, '0, '0, 1'b0);
      check($sformatf("vec%0d_phase0", i), 32'(ph[0]), 32'(tbl[i].ph0));
      check($sformatf("vec%0d_sample", i), 32'(samp), 32'(tbl[i].smp));
      check($sformatf("vec%0d_valid_cycle", i), 32'(vcyc), 32'd11);
      check($sformatf("vec%0d_busy", i), 32'(busy_ok), 32'd1);
    end
    check("no_overrun_yet", 32'(overrun), 32'h0);

    // tick in the sample_valid cycle starts the next frame without overrun
    mode = 0;
    frame(8'h01, -1, 0, '0, '0, 1'b1);
    check("b2b_f1_sample", 32'(samp), 32'h79000);
    check("b2b_f1_valid_cycle", 32'(vcyc), 32'd11);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("b2b_busy", 32'(busy), 32'h1);
    check("b2b_overrun", 32'(overrun), 32'h0);
    collect(-1, 0, '0, '0, 1'b0);
    check("b2b_f2_phase0", 32'(ph[0]), 32'hA000);
    check("b2b_f2_sample", 32'(samp), 32'h7A000);
    check("b2b_f2_valid_cycle", 32'(vcyc), 32'd11);

    // tick at cycle 4 is dropped and flagged
    frame(8'h01, 4, 1, '0, '0, 1'b0);
    check("ovr_phase0", 32'(ph[0]), 32'hB000);
    check("ovr_sample", 32'(samp), 32'h7B000);
    check("ovr_valid_cycle", 32'(vcyc), 32'd11);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_no_extra_frame", 32'(busy), 32'h0);

    // reset in cycle 5 aborts the frame
    voice_en = 8'h01;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    #1;
    check("midrst_phase_out", 32'(phase_out), 32'h0);
    check("midrst_sample_out", 32'(sample_out), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_overrun", 32'(overrun), 32'h0);
    step();
    rst = 1'b0;
    begin
      int nvalid = 0;
      for (int i = 0; i < 20; i++) begin
        if (sample_valid) nvalid++;
        step();
      end
      check("midrst_no_valid", 32'(nvalid), 32'd0);
    end
    frame(8'h01, -1, 0, '0, '0, 1'b0);
    check("postrst_valid_cycle", 32'(vcyc), 32'd11);
    check("postrst_busy", 32'(busy_ok), 32'd1);
    check("postrst_sample", 32'(samp), 32'h0);

    // phase wrap on voice 3
    wr(3'd3, 16'h8000);
    frame(8'h08, -1, 0, '0, '0, 1'b0);
    check("wrap_f1_phase3", 32'(ph[3]), 32'h0000);
    frame(8'h08, -1, 0, '0, '0, 1'b0);
    check("wrap_f2_phase3", 32'(ph[3]), 32'h8000);
    check("wrap_f2_sample", 32'(samp), 32'h78000);
    frame(8'h08, -1, 0, '0, '0, 1'b0);
    check("wrap_f3_phase3", 32'(ph[3]), 32'h0000);
    check("wrap_f3_sample", 32'(samp), 32'h0);
    check("wrap_overrun", 32'(overrun), 32'h0);

    // distinct increments: issue order and full mix
    do_reset();
    for (int v = 0; v < 8; v++) wr(3'(v), 16'((v + 1) * 16'h0100));
    frame(8'hFF, -1, 0, '0, '0, 1'b0);
    check("multi_f1_sample", 32'(samp), 32'h0);
    frame(8'hFF, -1, 0, '0, '0, 1'b0);
    for (int v = 0; v < 8; v++)
      check($sformatf("multi_phase%0d", v), 32'(ph[v]), 32'((v + 1) * 32'h100));
    check("multi_f2_sample", 32'(samp), 32'h2400);

    // increment rewritten while voice 2 is issued
    do_reset();
    wr(3'd2, 16'h0010);
    frame(8'h04, 2, 2, 16'h0100, 3'd2, 1'b0);
    check("fw_f1_phase2", 32'(ph[2]), 32'h0000);
    frame(8'h04, -1, 0, '0, '0, 1'b0);
    check("fw_f2_phase2", 32'(ph[2]), 32'h0010);
    check("fw_f2_sample", 32'(samp), 32'h00010);
    frame(8'h04, -1, 0, '0, '0, 1'b0);
    check("fw_f3_phase2", 32'(ph[2]), 32'h0110);
    check("fw_f3_sample", 32'(samp), 32'h00110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
